multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multicycle CPU. Sequences fetch/decode/execute/memory/writeback.
//  Drives PC, IR, register-file, ALU and memory controls from the OpCode/func fields latched by the IR.
//  IR latches on the edge that leaves IF, so OpCode/func are valid from ID onward.
// PARAMETERS
//  CNT_W   32   width of the performance counters (used only with CTRL_PERF_CNT_EN)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  OpCode     in   6      from IR
//  func       in   6      from IR
//  zero       in   1      ALU zero flag, valid in EXE
//  PC_Write   out  1      PC load enable
//  IR_Write   out  1      IR load enable
//  RegWrite   out  1      register-file write enable
//  MemRead    out  1      data-memory read strobe
//  MemWrite   out  1      data-memory write strobe
//  RegDst     out  1      1 = rd, 0 = rt
//  MemtoReg   out  1      1 = mem data, 0 = ALU result
//  ALUSrcA    out  1      1 = shamt, 0 = rs
//  ALUSrcB    out  1      1 = extended Imm, 0 = rt
//  ExtSel     out  1      1 = sign-extend, 0 = zero-extend
//  PCSrc      out  2      00 = PC+4, 01 = branch target, 10 = {PC[31:28], Imm_abs, 2'b00}
//  ALUOp      out  3      000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll
//  state      out  3      current state (debug)
//  halted     out  1      1 while in HALT
//  cyc_cnt    out  CNT_W  cycle counter
//  instr_cnt  out  CNT_W  retired-instruction counter
// BEHAVIOUR
//  - States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Codes 6-7 go to IF next cycle with all enables 0.
//  - Reset (rst_n low, async): state=IF; halted=0; counters=0.
//    All write/strobe outputs (PC_Write, IR_Write, RegWrite, MemRead, MemWrite) forced 0 while rst_n is low.
//  - Outputs are combinational from state, OpCode, func and zero.
//    Unlisted outputs are 0; ALUOp defaults to add.
//  - Decoded opcodes:
//    R=000000 (func: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000),
//    addi=001000, ori=001101, lw=100011, sw=101011, beq=000100, j=000010, halt=111111.
//  - IF: PC_Write=1, IR_Write=1, PCSrc=00 -> ID.
//  - ID: j -> PC_Write=1, PCSrc=10, -> IF. halt -> HALT.
//    Undefined opcode, or R with an undefined func -> IF (acts as nop). Otherwise -> EXE.
//  - EXE: ALU controls per instruction.
//    beq: ALUOp=sub, PCSrc=01, PC_Write=zero, -> IF.
//    lw/sw: ALUSrcB=1, ExtSel=1, add, -> MEM.
//    addi: ALUSrcB=1, ExtSel=1, add, -> WB.
//    ori: ALUSrcB=1, ExtSel=0, or, -> WB.
//    R: ALUOp from func; sll also sets ALUSrcA=1; -> WB.
//  - MEM: lw -> MemRead=1, -> WB. sw -> MemWrite=1, -> IF.
//  - WB: RegWrite=1, -> IF. R uses RegDst=1; lw uses MemtoReg=1; addi/ori use RegDst=0.
//    EXE ALU selects are held stable through WB.
//  - HALT: all enables 0, halted=1. Stays in HALT until reset.
//  - Cycle counts: R/addi/ori 4, lw 5, sw 4, beq 3, j 2.
//  - Reset mid-instruction aborts the instruction immediately. No partial write after rst_n rises.
// CONFIGURATION
//  - CTRL_PERF_CNT_EN defined:
//    cyc_cnt increments every cycle when state != HALT.
//    instr_cnt increments on each transition into IF or HALT from a non-IF state (one per retired instruction).
//    Both wrap modulo 2^CNT_W.
//  - CTRL_PERF_CNT_EN undefined: counter logic is omitted; cyc_cnt and instr_cnt are tied to 0.
// TESTING
//  1. Hold rst_n=0 for 3 cycles -> state=0, all enables 0.
//     Release -> first cycle PC_Write=1, IR_Write=1.
//  2. add (OpCode=0, func=100000) -> states 0,1,2,4,0.
//     RegWrite=1 only in WB, RegDst=1, ALUOp=000.
//  3. lw (100011) -> states 0,1,2,3,4, with MemRead=1 in MEM and MemtoReg=1 in WB.
//     sw (101011) -> MemWrite=1 in MEM, then IF.
//  4. beq: zero=1 in EXE -> PC_Write=1, PCSrc=01.
//     zero=0 -> PC_Write=0. Both return to IF after 3 cycles.
//  5. j -> PCSrc=10 with PC_Write=1 in ID, 2 cycles.
//     halt (111111) -> halted=1, state stays 5 for 100 cycles; reset clears it.
//  6. With CTRL_PERF_CNT_EN: add, lw, j, halt -> instr_cnt=4, cyc_cnt=13.
//     Assert rst_n low mid-MEM of lw -> MemRead drops at once, counters=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle CPU controller (master) and its datapath (slave).
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OpCode;
  logic [5:0]       func;
  logic             zero;
  logic             PC_Write;
  logic             IR_Write;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic             ExtSel;
  logic [1:0]       PCSrc;
  logic [2:0]       ALUOp;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  OpCode, func, zero,
    output PC_Write, IR_Write, RegWrite, MemRead, MemWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtSel, PCSrc, ALUOp, state, halted, cyc_cnt, instr_cnt
  );

  modport slave (
    output OpCode, func, zero,
    input  PC_Write, IR_Write, RegWrite, MemRead, MemWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtSel, PCSrc, ALUOp, state, halted, cyc_cnt, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main control FSM: IF/ID/EXE/MEM/WB/HALT sequencing with Moore/Mealy decode.
// Optional performance counters are built only when CTRL_PERF_CNT_EN is defined.
//
//   state | meaning
//   IF    | fetch: PC <- PC+4, IR loaded
//   ID    | decode: j/halt/nop resolved here
//   EXE   | ALU operation, beq resolves
//   MEM   | data-memory access (lw/sw)
//   WB    | register-file write
//   HALT  | stopped until reset
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    I_NOP, I_R, I_ADDI, I_ORI, I_LW, I_SW, I_BEQ, I_J, I_HALT
  } instr_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  state_e     state_q, state_d;
  instr_e     instr;
  logic [2:0] r_alu_op;
  logic       r_ok;
  logic       r_sll;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write;
  logic       reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_sel;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_hold;

  always_comb begin
    r_alu_op = ALU_ADD;
    r_ok     = 1'b1;
    r_sll    = 1'b0;
    case (bus.func)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b101010: r_alu_op = ALU_SLT;
      6'b000000: begin
        r_alu_op = ALU_SLL;
        r_sll    = 1'b1;
      end
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    instr = I_NOP;
    case (bus.OpCode)
      6'b000000: instr = r_ok ? I_R : I_NOP;
      6'b001000: instr = I_ADDI;
      6'b001101: instr = I_ORI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b111111: instr = I_HALT;
      default:   instr = I_NOP;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    ext_sel    = 1'b0;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    alu_hold   = 1'b0;

    case (state_q)
      S_IF: begin
        pc_write = 1'b1;
        ir_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        case (instr)
          I_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_IF;
          end
          I_HALT:  state_d = S_HALT;
          I_NOP:   state_d = S_IF;
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        alu_hold = 1'b1;
        case (instr)
          I_BEQ: begin
            pc_src   = 2'b01;
            pc_write = bus.zero;
            state_d  = S_IF;
          end
          I_LW, I_SW:         state_d = S_MEM;
          I_ADDI, I_ORI, I_R: state_d = S_WB;
          default:            state_d = S_IF;
        endcase
      end
      S_MEM: begin
        alu_hold = 1'b1;
        case (instr)
          I_LW: begin
            mem_read = 1'b1;
            state_d  = S_WB;
          end
          I_SW: begin
            mem_write = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        alu_hold   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = (instr == I_R);
        mem_to_reg = (instr == I_LW);
        state_d    = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // ALU selects are set in EXE and kept until the instruction retires
    if (alu_hold) begin
      case (instr)
        I_LW, I_SW, I_ADDI: begin
          alu_src_b = 1'b1;
          ext_sel   = 1'b1;
        end
        I_ORI: begin
          alu_src_b = 1'b1;
          alu_op    = ALU_OR;
        end
        I_BEQ: alu_op = ALU_SUB;
        I_R: begin
          alu_op    = r_alu_op;
          alu_src_a = r_sll;
        end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Write strobes are gated by reset so an aborted instruction cannot leak a write
  assign bus.PC_Write = pc_write  & rst_n;
  assign bus.IR_Write = ir_write  & rst_n;
  assign bus.RegWrite = reg_write & rst_n;
  assign bus.MemRead  = mem_read  & rst_n;
  assign bus.MemWrite = mem_write & rst_n;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ExtSel   = ext_sel;
  assign bus.PCSrc    = pc_src;
  assign bus.ALUOp    = alu_op;
  assign bus.state    = state_q;
  assign bus.halted   = (state_q == S_HALT);

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;

  always_comb begin
    retire      = (state_q != S_IF) && (state_q != S_HALT) &&
                  ((state_d == S_IF) || (state_d == S_HALT));
    cyc_cnt_d   = cyc_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_HALT) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    if (retire) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.cyc_cnt   = cyc_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`else
  assign bus.cyc_cnt   = {CNT_W{1'b0}};
  assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule
